// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants and types for the data-memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
    localparam int          DEF_RAM_WORDS = 1024;
    localparam logic [31:0] DEF_IO_BASE   = 32'hFFFF_0000;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_GPIO   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_WCNT   = 4'hC;

    localparam int ST_MISALIGN = 0;
    localparam int ST_UNMAPPED = 1;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_IO   = 2'd1,
        REGION_NONE = 2'd2
    } region_t;

    // STATUS register as seen on the bus: only the two sticky bits are backed.
    function automatic logic [31:0] status_word(input logic [1:0] st);
        return {30'd0, st};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : Word-wide RAM with synchronous write and asynchronous read.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_ram #(
    parameter int RAM_WORDS = 1024,
    parameter int AW        = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wd,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rd
);

    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wd;
        end
    end

    assign rd = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : CPU data-port responder: RAM + MMIO decode, sticky error status.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
    parameter int          RAM_WORDS = DEF_RAM_WORDS,
    parameter logic [31:0] IO_BASE   = DEF_IO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DM_CS,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] gpio_out,
    output logic        err_irq
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    logic [31:0] r_cycle;
    logic [31:0] r_gpio;
    logic [1:0]  r_status;
    logic [31:0] r_wcnt;

    logic [31:0] w_ram_off;
    logic        w_ram_hit;
    logic        w_io_hit;
    region_t     w_region;
    logic        w_access;
    logic        w_misalign;
    logic        w_unmapped;
    logic        w_err;
    logic        w_wr_ok;
    logic        w_rd_ok;
    logic        w_ram_we;
    logic        w_gpio_we;
    logic        w_status_clr;
    logic        w_wcnt_inc;
    logic [31:0] w_ram_rd;
    logic [31:0] w_rdata;

    // Unsigned offset compare also rejects addresses below RAM_BASE via wrap.
    assign w_ram_off = addr - RAM_BASE;
    assign w_ram_hit = {1'b0, w_ram_off} < RAM_BYTES;
    assign w_io_hit  = addr[31:4] == IO_BASE[31:4];

    always_comb begin
        w_region = REGION_NONE;
        if (w_ram_hit) begin
            w_region = REGION_RAM;
        end else if (w_io_hit) begin
            w_region = REGION_IO;
        end
    end

    assign w_access   = DM_CS & (DM_R | DM_W);
    assign w_misalign = addr[1:0] != 2'b00;
    assign w_unmapped = w_region == REGION_NONE;
    assign w_err      = w_misalign | w_unmapped;

    assign w_wr_ok      = DM_CS & DM_W & ~reset & ~w_err;
    assign w_rd_ok      = DM_CS & DM_R & ~w_err;
    assign w_ram_we     = w_wr_ok & (w_region == REGION_RAM);
    assign w_gpio_we    = w_wr_ok & (w_region == REGION_IO) & (addr[3:0] == OFF_GPIO);
    assign w_status_clr = w_wr_ok & (w_region == REGION_IO) & (addr[3:0] == OFF_STATUS);
    assign w_wcnt_inc   = (w_ram_we | w_gpio_we) & (r_wcnt != 32'hFFFF_FFFF);

    dmem_ram #(
        .RAM_WORDS (RAM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_off[AW+1:2]),
        .wd    (wdata),
        .raddr (w_ram_off[AW+1:2]),
        .rd    (w_ram_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle  <= 32'd0;
            r_gpio   <= 32'd0;
            r_status <= 2'b00;
            r_wcnt   <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_gpio_we) begin
                r_gpio <= wdata;
            end
            // A clearing write is never itself erroneous, so set and clear are exclusive.
            if (w_status_clr) begin
                r_status <= 2'b00;
            end else if (w_access) begin
                r_status[ST_MISALIGN] <= r_status[ST_MISALIGN] | w_misalign;
                r_status[ST_UNMAPPED] <= r_status[ST_UNMAPPED] | w_unmapped;
            end
            if (w_wcnt_inc) begin
                r_wcnt <= r_wcnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_rd_ok) begin
            case (w_region)
                REGION_RAM: w_rdata = w_ram_rd;
                REGION_IO: begin
                    case (addr[3:0])
                        OFF_CYCLE:  w_rdata = r_cycle;
                        OFF_GPIO:   w_rdata = r_gpio;
                        OFF_STATUS: w_rdata = status_word(r_status);
                        OFF_WCNT:   w_rdata = r_wcnt;
                        default:    w_rdata = 32'd0;
                    endcase
                end
                default: w_rdata = 32'd0;
            endcase
        end
    end

    assign rdata    = w_rdata;
    assign gpio_out = r_gpio;
    assign err_irq  = |r_status;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed plus random checks of dmem_responder against a map model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        DM_CS;
    logic        DM_R;
    logic        DM_W;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] gpio_out;
    logic        err_irq;

    int n_assert;
    int n_fail;

    // Reference state: plain counters and a sparse word map.
    logic [31:0] m_ram [int];
    logic [31:0] m_cycle;
    logic [31:0] m_gpio;
    logic [31:0] m_wcnt;
    bit          m_mis;
    bit          m_unm;

    dmem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .DM_CS    (DM_CS),
        .DM_R     (DM_R),
        .DM_W     (DM_W),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .err_irq  (err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a >= 32'h1001_0000 && a < 32'h1001_1000) return 0;
        if ((a & 32'hFFFF_FFF0) == 32'hFFFF_0000) return 1;
        return 2;
    endfunction

    task automatic model_read(input logic cs, r, input logic [31:0] a,
                              output logic [31:0] exp, output bit known);
        int idx;
        known = 1'b1;
        exp   = 32'd0;
        if (!(cs && r) || a % 4 != 0 || region(a) == 2) return;
        if (region(a) == 0) begin
            idx = int'((a - 32'h1001_0000) / 4);
            if (m_ram.exists(idx)) exp = m_ram[idx];
            else known = 1'b0;
        end else begin
            case (a % 16)
                0:  exp = m_cycle;
                4:  exp = m_gpio;
                8:  exp = {30'd0, m_unm, m_mis};
                12: exp = m_wcnt;
                default: exp = 32'd0;
            endcase
        end
    endtask

    task automatic model_commit(input logic rst, cs, r, w, input logic [31:0] a, d);
        bit bad;
        if (rst) begin
            m_cycle = 0; m_gpio = 0; m_wcnt = 0; m_mis = 0; m_unm = 0;
            return;
        end
        m_cycle = m_cycle + 1;
        bad = (a % 4 != 0) || (region(a) == 2);
        if (cs && (r || w)) begin
            if (a % 4 != 0) m_mis = 1;
            if (region(a) == 2) m_unm = 1;
        end
        if (cs && w && !bad) begin
            if (region(a) == 0) begin
                m_ram[int'((a - 32'h1001_0000) / 4)] = d;
                if (m_wcnt != 32'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
            end else if (a % 16 == 4) begin
                m_gpio = d;
                if (m_wcnt != 32'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
            end else if (a % 16 == 8) begin
                m_mis = 0;
                m_unm = 0;
            end
        end
    endtask

    // One bus cycle: drive at the falling edge, check mid-cycle, commit model at the rising edge.
    task automatic cyc(input logic rst, cs, r, w, input logic [31:0] a, d,
                       output logic [31:0] rd_obs);
        logic [31:0] exp;
        bit          known;
        reset = rst; DM_CS = cs; DM_R = r; DM_W = w; addr = a; wdata = d;
        #1;
        rd_obs = rdata;
        model_read(cs, r, a, exp, known);
        if (known) check("rdata", rdata, exp);
        check("gpio_out", gpio_out, m_gpio);
        check("err_irq", {31'd0, err_irq}, {31'd0, m_mis | m_unm});
        @(posedge clk);
        model_commit(rst, cs, r, w, a, d);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 32'h1001_0000 + 4 * $urandom_range(0, 15);
            4, 5:       a = 32'hFFFF_0000 + 4 * $urandom_range(0, 3);
            6:          a = 32'h1001_0000 + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            7:          a = 32'hFFFF_0000 + $urandom_range(0, 15);
            8:          a = 32'h1001_0FFC + 4 * $urandom_range(0, 1);
            default: begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h2000_0000;
                    1:       a = 32'h1000_FFFC;
                    default: a = 32'hFFFF_0010;
                endcase
            end
        endcase
        return a;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] wcnt_before;
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1; DM_CS = 0; DM_R = 0; DM_W = 0; addr = 0; wdata = 0;
        m_cycle = 0; m_gpio = 0; m_wcnt = 0; m_mis = 0; m_unm = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_gpio", gpio_out, 32'd0);
        check("reset_irq", {31'd0, err_irq}, 32'd0);

        cyc(0, 1, 1, 0, 32'hFFFF_0000, 0, rd);
        check("cycle_after_reset", rd, 32'd0);

        // Basic write/read and write counter
        cyc(0, 1, 0, 1, 32'h1001_0004, 32'hDEADBEEF, rd);
        cyc(0, 1, 1, 0, 32'h1001_0004, 0, rd);
        check("ram_readback", rd, 32'hDEADBEEF);
        cyc(0, 1, 1, 0, 32'hFFFF_000C, 0, rd);
        check("wcnt_one", rd, 32'd1);

        // Simultaneous read and write returns old data
        cyc(0, 1, 0, 1, 32'h1001_0008, 32'h11, rd);
        cyc(0, 1, 1, 1, 32'h1001_0008, 32'h22, rd);
        check("rw_old", rd, 32'h11);
        cyc(0, 1, 1, 0, 32'h1001_0008, 0, rd);
        check("rw_new", rd, 32'h22);

        // Misaligned write is dropped and flagged
        cyc(0, 1, 0, 1, 32'h1001_0000, 32'h1234_5678, rd);
        cyc(0, 1, 0, 1, 32'h1001_0002, 32'hFFFF_FFFF, rd);
        check("misalign_irq", {31'd0, err_irq}, 32'd1);
        cyc(0, 1, 1, 0, 32'hFFFF_0008, 0, rd);
        check("status_mis", rd, 32'h1);
        cyc(0, 1, 1, 0, 32'h1001_0000, 0, rd);
        check("ram_unchanged", rd, 32'h1234_5678);
        cyc(0, 1, 0, 1, 32'hFFFF_0008, 32'hABCD, rd);
        check("status_clr_irq", {31'd0, err_irq}, 32'd0);

        // Unmapped reads
        cyc(0, 1, 1, 0, 32'h2000_0000, 0, rd);
        check("unmapped_rdata", rd, 32'd0);
        cyc(0, 1, 1, 0, 32'hFFFF_0008, 0, rd);
        check("status_unm", rd, 32'h2);
        cyc(0, 1, 0, 1, 32'hFFFF_0008, 0, rd);
        cyc(0, 1, 1, 0, 32'h1001_1000, 0, rd);
        cyc(0, 1, 1, 0, 32'hFFFF_0008, 0, rd);
        check("past_end_unm", rd, 32'h2);
        cyc(0, 1, 0, 1, 32'hFFFF_0008, 0, rd);

        // GPIO, read-only writes, reset during a write
        cyc(0, 1, 0, 1, 32'hFFFF_0004, 32'hA5, rd);
        check("gpio_a5", gpio_out, 32'hA5);
        wcnt_before = m_wcnt;
        cyc(0, 1, 0, 1, 32'hFFFF_0000, 32'h5, rd);
        cyc(0, 1, 1, 0, 32'hFFFF_000C, 0, rd);
        check("ro_write_wcnt", rd, wcnt_before);
        cyc(1, 1, 0, 1, 32'h1001_0004, 32'h0BAD_0BAD, rd);
        check("reset_gpio_mid", gpio_out, 32'd0);
        cyc(0, 1, 1, 0, 32'h1001_0004, 0, rd);
        check("reset_write_suppressed", rd, 32'hDEADBEEF);

        // Counter wrap and write-count saturation via deposit
        dut.r_cycle = 32'hFFFF_FFFF;
        m_cycle     = 32'hFFFF_FFFF;
        cyc(0, 0, 0, 0, 32'd0, 0, rd);
        cyc(0, 1, 1, 0, 32'hFFFF_0000, 0, rd);
        check("cycle_wrap", rd, 32'd0);
        dut.r_wcnt = 32'hFFFF_FFFF;
        m_wcnt     = 32'hFFFF_FFFF;
        cyc(0, 1, 0, 1, 32'h1001_000C, 32'h77, rd);
        cyc(0, 1, 1, 0, 32'hFFFF_000C, 0, rd);
        check("wcnt_sat", rd, 32'hFFFF_FFFF);
        cyc(1, 0, 0, 0, 32'd0, 0, rd);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rand_addr(), $urandom(), rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
